// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e  - fetch FSM state (idle / live request / stale request)
//   NopWord        - instruction word shown on an empty, freshly reset buffer
//   DefaultPcWidth - default PC / instruction memory address width
//   DefaultResetPc - default fetch PC after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,  // no request outstanding
    StReq  = 2'd1,  // request outstanding for the current fetch PC
    StDrop = 2'd2   // request outstanding for a stale PC, response is discarded
  } fetch_state_e;

  localparam logic [31:0] NopWord        = 32'h0000_0000;
  localparam int unsigned DefaultPcWidth = 8;
  localparam int unsigned DefaultResetPc = 0;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction memory handshake, the decode handshake and the
// branch redirect into one port.
//   master - fetch unit side: drives imem_req/imem_addr and inst_valid/inst_data/inst_pc
//   slave  - environment side: drives imem_ack/imem_rdata, inst_ready, redirect/redirect_pc
interface fetch_if import fetch_pkg::*; #(
  parameter int unsigned PC_WIDTH = DefaultPcWidth
) ();

  // Instruction memory request/ack
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  // Decode valid/ready
  logic                inst_valid;
  logic                inst_ready;
  logic [31:0]         inst_data;
  logic [PC_WIDTH-1:0] inst_pc;

  // Taken branch from execute
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch buffer, DEPTH entries of WIDTH bits.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_push     - write i_wdata at the tail (ignored when full)
//   i_wdata    - entry to write
//   i_pop      - remove the head (ignored when empty)
//   i_flush    - empty the buffer; wins over a same-cycle push
//   o_valid    - head entry is valid
//   o_rdata    - head entry (registered storage, no bypass from i_wdata)
//   o_count    - number of stored entries
module fetch_fifo #(
  parameter int unsigned      WIDTH     = 40,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     PTR_W     = $clog2(DEPTH),
  localparam int unsigned     CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_valid   = (r_count != '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & o_valid;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_VAL;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, issues one request at a time to
// instruction memory (req held until ack), buffers returned words in fetch_fifo and hands
// them to decode. A redirect retargets the fetch PC, flushes the buffer and, if a request
// is still in flight, marks its response as stale so it is dropped.
//   clk, rst_n - clock, asynchronous active-low reset
//   io_bus     - fetch_if master: imem req/addr/ack/rdata, inst valid/ready/data/pc,
//                redirect/redirect_pc
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned         PC_WIDTH = DefaultPcWidth,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DefaultResetPc)
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  io_bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // One extra bit so count + 1 cannot wrap in the room check.
  localparam int unsigned LVL_W = CNT_W + 1;

  fetch_state_e        r_state;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic                r_imem_req;
  logic [PC_WIDTH-1:0] r_imem_addr;

  logic                w_ack;
  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic                w_push;
  logic                w_pop;
  logic                w_has_room;
  logic                w_room_after;
  logic [LVL_W-1:0]    w_level_after;
  logic [CNT_W-1:0]    w_count;
  logic                w_fifo_valid;
  logic [PC_WIDTH+31:0] w_fifo_rdata;

  // An ack only means something while a request is actually up.
  assign w_ack      = r_imem_req & io_bus.imem_ack;
  assign w_redirect = io_bus.redirect;
  assign w_target   = io_bus.redirect_pc & ~PC_WIDTH'(3);
  assign w_pc_next  = r_fetch_pc + PC_WIDTH'(4);
  assign w_pop      = w_fifo_valid & io_bus.inst_ready;

  // Only a live (non-stale) response that is not being flushed enters the buffer.
  assign w_push = (r_state == StReq) & w_ack & ~w_redirect;

  assign w_has_room    = (w_count < CNT_W'(DEPTH));
  assign w_level_after = LVL_W'(w_count) + LVL_W'(1) - LVL_W'(w_pop);
  // Keep requesting back-to-back only if the word just accepted still leaves a free slot,
  // so an issued request always has somewhere to land.
  assign w_room_after  = (w_level_after < LVL_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
          end else if (w_has_room) begin
            r_state     <= StReq;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
          end
        end

        StReq: begin
          if (w_ack) begin
            if (w_redirect) begin
              r_state    <= StIdle;
              r_imem_req <= 1'b0;
              r_fetch_pc <= w_target;
            end else begin
              r_fetch_pc <= w_pc_next;
              if (w_room_after) begin
                r_imem_addr <= w_pc_next;
              end else begin
                r_state    <= StIdle;
                r_imem_req <= 1'b0;
              end
            end
          end else if (w_redirect) begin
            // The request must stay up until acked; its data is now stale.
            r_state    <= StDrop;
            r_fetch_pc <= w_target;
          end
        end

        StDrop: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
          end
          if (w_ack) begin
            r_state    <= StIdle;
            r_imem_req <= 1'b0;
          end
        end

        default: begin
          r_state    <= StIdle;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH     (PC_WIDTH + 32),
    .DEPTH     (DEPTH),
    .RESET_VAL ({{PC_WIDTH{1'b0}}, NopWord})
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({r_fetch_pc, io_bus.imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_valid (w_fifo_valid),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count)
  );

  assign io_bus.imem_req   = r_imem_req;
  assign io_bus.imem_addr  = r_imem_addr;
  assign io_bus.inst_valid = w_fifo_valid;
  assign io_bus.inst_pc    = w_fifo_rdata[PC_WIDTH+31:32];
  assign io_bus.inst_data  = w_fifo_rdata[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with directed and randomized memory latency, decode
// back-pressure and redirects, and checks every cycle against a transaction-level model
// (queue of expected buffered PCs, next fresh fetch PC, stale-response flag).
module tb_fetch_unit;

  localparam int PCW   = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;

  fetch_if #(.PC_WIDTH(PCW)) bus ();

  fetch_unit #(
    .PC_WIDTH (PCW),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Model state
  logic [7:0] exp_q[$];
  logic [7:0] got_pops[$];
  logic [7:0] exp_pc;
  bit         stale;

  // Memory responder state and knobs
  bit         resp_busy;
  int         wait_left;
  int         lat_min, lat_max;
  bit         slow_en;
  logic [7:0] slow_addr;
  int         slow_lat;
  int         ready_pct, redir_pct, spur_pct;
  bit         redir_force;
  logic [7:0] redir_tgt;

  // Previous-cycle handshake snapshot
  bit         prev_ok, prev_req, prev_acc, prev_redir, prev_stale;
  logic [7:0] prev_addr;
  int         prev_size;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, 8'h5A, ~a, a ^ 8'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pop(input int idx, input logic [7:0] exp);
    if (idx < got_pops.size()) chk($sformatf("pop%0d_pc", idx), 32'(got_pops[idx]), 32'(exp));
    else chk("pop_count", 32'(got_pops.size()), 32'(idx + 1));
  endtask

  task automatic model_reset();
    exp_q.delete();
    got_pops.delete();
    exp_pc      = 8'h00;
    stale       = 1'b0;
    resp_busy   = 1'b0;
    wait_left   = 0;
    prev_ok     = 1'b0;
    redir_force = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: check outputs, choose inputs for the coming edge, advance the model.
  task automatic step();
    logic       req, valid, rdy, ack, rdr, acc, pop;
    logic [7:0] addr, pc, tgt;
    logic [31:0] data;
    int         sz;

    req   = bus.imem_req;
    addr  = bus.imem_addr;
    valid = bus.inst_valid;
    pc    = bus.inst_pc;
    data  = bus.inst_data;
    sz    = exp_q.size();

    chk("inst_valid", 32'(valid), 32'(sz != 0));
    if (sz != 0) begin
      chk("inst_pc", 32'(pc), 32'(exp_q[0]));
      chk("inst_data", data, mem_word(exp_q[0]));
    end
    if (req && !stale) chk("imem_addr", 32'(addr), 32'(exp_pc));
    if (prev_ok) begin
      if (prev_req && !prev_acc) begin
        chk("req_held", 32'(req), 32'(1));
        chk("addr_held", 32'(addr), 32'(prev_addr));
      end else if (prev_req) begin
        chk("req_after_ack", 32'(req), 32'(!prev_redir && !prev_stale && (sz < DEPTH)));
      end else begin
        chk("req_issue", 32'(req), 32'(!prev_redir && (prev_size < DEPTH)));
      end
    end

    rdy = ($urandom_range(99) < ready_pct);
    ack = 1'b0;
    if (req) begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        wait_left = (slow_en && addr == slow_addr) ? slow_lat : $urandom_range(lat_max, lat_min);
      end
      if (wait_left == 0) begin
        ack       = 1'b1;
        resp_busy = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      ack = ($urandom_range(99) < spur_pct);
    end
    rdr = redir_force || ($urandom_range(99) < redir_pct);
    tgt = redir_force ? redir_tgt : 8'($urandom);
    redir_force = 1'b0;

    bus.imem_ack    = ack;
    bus.imem_rdata  = (ack && req) ? mem_word(addr) : $urandom;
    bus.inst_ready  = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = tgt;

    acc = req && ack;
    pop = (sz != 0) && rdy;
    prev_stale = stale;
    if (pop) begin
      got_pops.push_back(pc);
      void'(exp_q.pop_front());
    end
    if (rdr) begin
      exp_q.delete();
      if (acc) stale = 1'b0;
      else if (req) stale = 1'b1;
      exp_pc = tgt & 8'hFC;
    end else if (acc) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        chk("fifo_room", 32'(exp_q.size() < DEPTH), 32'(1));
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 8'd4;
      end
    end

    prev_ok    = 1'b1;
    prev_req   = req;
    prev_acc   = acc;
    prev_addr  = addr;
    prev_redir = rdr;
    prev_size  = sz;
    @(negedge clk);
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rdy, input int rdr,
                       input int spur);
    lat_min   = lmin;
    lat_max   = lmax;
    ready_pct = rdy;
    redir_pct = rdr;
    spur_pct  = spur;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    slow_en = 1'b0;
    slow_addr = 8'h00;
    slow_lat  = 0;
    knobs(0, 0, 100, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_imem_req", 32'(bus.imem_req), 32'(0));
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'(8'h00));
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'(0));
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'(0));

    // Zero-wait memory, decode always ready: one instruction per cycle
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        chk("a_first_req", 32'(bus.imem_req), 32'(1));
        chk("a_first_addr", 32'(bus.imem_addr), 32'(8'h00));
      end
      if (i >= 2 && i <= 5) begin
        chk("a_valid", 32'(bus.inst_valid), 32'(1));
        chk("a_pc", 32'(bus.inst_pc), 32'(4 * (i - 2)));
      end
      step();
    end

    // Ack delayed 3 cycles
    do_reset();
    knobs(3, 3, 100, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i >= 1 && i <= 4) begin
        chk("b_req_wait", 32'(bus.imem_req), 32'(1));
        chk("b_addr_wait", 32'(bus.imem_addr), 32'(8'h00));
        chk("b_valid_wait", 32'(bus.inst_valid), 32'(0));
      end
      if (i == 5) begin
        chk("b_valid_after_ack", 32'(bus.inst_valid), 32'(1));
        chk("b_pc_after_ack", 32'(bus.inst_pc), 32'(8'h00));
      end
      step();
    end

    // Decode stalled for 10 cycles: exactly DEPTH fetched, then release
    do_reset();
    knobs(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i >= 3) chk("c_req_stalled", 32'(bus.imem_req), 32'(0));
      step();
    end
    chk("c_buffered", 32'(exp_q.size()), 32'(2));
    ready_pct = 100;
    for (int i = 0; i < 8; i++) step();
    chk_pop(0, 8'h00);
    chk_pop(1, 8'h04);
    chk_pop(2, 8'h08);

    // Redirect while the request to 0x08 is still pending
    do_reset();
    knobs(0, 0, 100, 0, 0);
    slow_en   = 1'b1;
    slow_addr = 8'h08;
    slow_lat  = 3;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        chk("d_req_pending", 32'(bus.imem_req), 32'(1));
        chk("d_addr_pending", 32'(bus.imem_addr), 32'(8'h08));
        redir_force = 1'b1;
        redir_tgt   = 8'h40;
      end
      if (i >= 5 && i <= 8) chk("d_empty", 32'(bus.inst_valid), 32'(0));
      step();
    end
    slow_en = 1'b0;
    chk_pop(0, 8'h00);
    chk_pop(1, 8'h04);
    chk_pop(2, 8'h40);
    chk_pop(3, 8'h44);

    // Redirect coincident with ack and pop
    do_reset();
    knobs(0, 0, 100, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        chk("e_pop_pc", 32'(bus.inst_pc), 32'(8'h04));
        chk("e_ack_addr", 32'(bus.imem_addr), 32'(8'h08));
        redir_force = 1'b1;
        redir_tgt   = 8'h80;
      end
      step();
    end
    chk_pop(0, 8'h00);
    chk_pop(1, 8'h04);
    chk_pop(2, 8'h80);

    // Redirect near the top of the address space: wrap, low target bits ignored
    do_reset();
    knobs(0, 0, 100, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        redir_force = 1'b1;
        redir_tgt   = 8'hF9;
      end
      step();
    end
    chk_pop(0, 8'hF8);
    chk_pop(1, 8'hFC);
    chk_pop(2, 8'h00);

    // Reset pulsed in the middle of a request
    knobs(3, 3, 100, 0, 0);
    step();
    step();
    chk("f_req_before_rst", 32'(bus.imem_req), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("f_req_async_rst", 32'(bus.imem_req), 32'(0));
    chk("f_valid_async_rst", 32'(bus.inst_valid), 32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    knobs(0, 0, 100, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        chk("f_restart_req", 32'(bus.imem_req), 32'(1));
        chk("f_restart_addr", 32'(bus.imem_addr), 32'(8'h00));
      end
      step();
    end
    chk_pop(0, 8'h00);

    // Randomized traffic
    do_reset();
    knobs(0, 3, 70, 4, 10);
    for (int i = 0; i < 3000; i++) step();
    knobs(0, 1, 30, 8, 10);
    for (int i = 0; i < 1000; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle datapath's decode/execute logic. It owns the fetch PC, issues requests to instruction memory over a req/ack handshake with variable latency, and buffers returned instructions in a small prefetch FIFO. Decode consumes buffered instructions through a valid/ready handshake. A taken branch from execute redirects the fetch PC, flushes the buffer and discards any in-flight stale response.

## Interface
Parameters:
- PC_WIDTH, 8, byte-address width of the PC and instruction memory address
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, fetch PC after reset

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  request valid; held high until imem_ack
- imem_addr  out  PC_WIDTH  request address; stable while imem_req high
- imem_ack  in  1  one-cycle pulse; data valid this cycle; ignored unless imem_req high
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_ack
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head; pop on inst_valid && inst_ready
- inst_data  out  32  FIFO head instruction
- inst_pc  out  PC_WIDTH  byte address of inst_data
- redirect  in  1  taken branch, one cycle
- redirect_pc  in  PC_WIDTH  branch target; bits [1:0] forced to 0

## Operation
- FSM states: IDLE (no request), REQ (live request at fetch_pc), DROP (request outstanding for stale address, response to be discarded).
- IDLE: if count < DEPTH and no redirect → REQ, imem_addr <= fetch_pc.
- REQ, ack, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4. If count+1−pop < DEPTH stay REQ with imem_addr <= fetch_pc+4, else IDLE.
- REQ, no ack, redirect → DROP; fetch_pc <= redirect_pc; imem_addr held.
- REQ, ack and redirect same cycle: data discarded, → IDLE, fetch_pc <= redirect_pc.
- DROP, ack: discard data → IDLE. Redirect in DROP: update fetch_pc, stay DROP.
- IDLE, redirect: fetch_pc <= redirect_pc, stay IDLE that cycle.
- Redirect flushes FIFO (count <= 0) at the same edge; a simultaneous pop is still a completed transfer to decode; a simultaneous push is dropped.
- At most one request outstanding; FIFO never overflows because issue requires free space.
- PC arithmetic modulo 2^PC_WIDTH; 0xFC + 4 wraps to 0x00 (PC_WIDTH=8).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0, fetch_pc RESET_PC, state IDLE, count 0.
- Reset assertion mid-request drops the request immediately (asynchronously); no response is tracked afterwards.
- First request: imem_req high in the first cycle after the first clock edge with rst_n high.
- All outputs registered; imem_ack may arrive in the same cycle imem_req rises.
- Ack at edge N → inst_valid high from cycle N+1 (FIFO is not fall-through-bypassed).
- Zero-wait memory and inst_ready held high: one instruction per cycle sustained.
- Redirect at edge N: inst_valid low in cycle N+1; first target instruction valid no earlier than N+3 (IDLE→REQ→ack).

## Structure
- Package fetch_pkg: FSM state enum (IDLE, REQ, DROP), NOP word constant 32'h0000_0000, default PC_WIDTH and RESET_PC.
- Sub-module fetch_fifo: synchronous FIFO, DEPTH×(PC_WIDTH+32), push/pop/flush, count output, async active-low reset; flush has priority over push.
- fetch_unit holds the FSM, fetch_pc and handshake logic only.

## Test plan
- Reset then zero-wait ack, inst_ready=1: inst_pc sequence 0x00,0x04,0x08… one per cycle, inst_data matches memory.
- Ack delayed 3 cycles: imem_addr stays 0x00 with imem_req high until ack; inst_valid rises the cycle after ack.
- inst_ready=0 for 10 cycles: exactly DEPTH=2 entries fetched, imem_req low afterwards; release → 0x00,0x04,0x08 in order, none lost.
- Redirect to 0x40 while request to 0x08 pending 2 more cycles: 0x08 response discarded, next inst_pc is 0x40, FIFO empty in between.
- Redirect coincident with ack and pop: popped entry delivered once, acked word dropped, next inst_pc equals redirect target.
- Redirect to 0xF8 (PC_WIDTH=8): sequence 0xF8, 0xFC, 0x00; rst_n pulsed low mid-request → imem_req 0 immediately, restart at 0x00.
